// File: rtl/data_tx.sv
// data_tx: transmit-side FIFO buffer with valid/ready output handshake and
// frame-boundary marking.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   data_i   - write data from the producer
//   valid_i  - write request
//   ready_o  - FIFO can accept a word (level != DEPTH)
//   flush_i  - synchronous clear of FIFO and frame counter (wins over read/write)
//   data_o   - head-of-FIFO word, zero when empty
//   valid_o  - data_o is valid (level != 0)
//   ready_i  - receiver accepts data_o
//   last_o   - data_o is the final beat of the current frame
//   level_o  - number of stored words
//
// All outputs are decoded from registered state only; there is no
// combinational path from any input to any output.
module data_tx #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       last_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] beat_cnt;

    logic wr_en;
    logic rd_en;
    logic cnt_at_end;

    // Handshake qualifiers and status decode
    always_comb begin
        ready_o    = (level != LVL_W'(DEPTH));
        valid_o    = (level != LVL_W'(0));
        wr_en      = valid_i && ready_o;
        rd_en      = valid_o && ready_i;
        cnt_at_end = (beat_cnt == CNT_W'(FRAME_LEN - 1));
        last_o     = valid_o && cnt_at_end;
        data_o     = valid_o ? mem[rd_ptr] : '0;
        level_o    = level;
    end

    // Storage array; contents are don't-care after reset so it carries no reset
    always_ff @(posedge clk_i) begin
        if (wr_en && !flush_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers, fill level and frame beat counter; flush overrides any transfer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            beat_cnt <= '0;
        end else if (flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            beat_cnt <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is modulo DEPTH
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                beat_cnt <= cnt_at_end ? '0 : beat_cnt + CNT_W'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule
